// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the serial_addsub digit-serial adder/subtractor.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic ADD = 1'b1;
    localparam logic SUB = 1'b0;

    // Counter width for n digits; never narrower than one bit so N=1 still elaborates.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_addsub_if.sv
// Request/result bundle of serial_addsub; master issues operations, slave computes them.
interface serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             a_ns;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a_ns, cin, a, b,
        input  ready, busy, done, s, cout, ovf
    );

    modport slave (
        input  start, a_ns, cin, a, b,
        output ready, busy, done, s, cout, ovf
    );
endinterface

// File: rtl/serial_addsub_digit.sv
// Combinational DIGIT-bit ripple-carry slice reused every cycle by serial_addsub.
module addsub_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] sum,
    output logic             co
);

    // Ripple the carry through the slice, LSB first.
    always_comb begin : p_ripple
        logic c;
        c   = ci;
        sum = '0;
        for (int i = 0; i < DIGIT; i++) begin
            sum[i] = x[i] ^ y[i] ^ c;
            c      = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        co = c;
    end

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial WIDTH-bit adder/subtractor: one DIGIT-bit slice per clock with a registered carry,
// start/done handshake, carry/borrow in and signed overflow detection.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    serial_addsub_if.slave  bus
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_width(N);

    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
        $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               ready_q, ready_d;

    logic [DIGIT-1:0]       sum_s;
    logic                   co_s;
    logic [WIDTH+DIGIT-1:0] res_ext_s;
    logic                   last_s;

    // a_q and b_q shift right each RUN cycle, so the current digit is always at the bottom.
    addsub_digit #(.DIGIT(DIGIT)) u_digit (
        .x   (a_q[DIGIT-1:0]),
        .y   (b_q[DIGIT-1:0]),
        .ci  (carry_q),
        .sum (sum_s),
        .co  (co_s)
    );

    assign res_ext_s = {sum_s, res_q};
    assign last_s    = (cnt_q == CW'(N - 1));

    // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
        ready_d = ready_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    // Subtraction becomes a + ~b + ~borrow, so RUN only ever adds.
                    a_d     = bus.a;
                    b_d     = (bus.a_ns == ADD) ? bus.b : ~bus.b;
                    carry_d = (bus.a_ns == ADD) ? bus.cin : ~bus.cin;
                    cnt_d   = '0;
                    res_d   = '0;
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                    state_d = RUN;
                end else begin
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = co_s;
                res_d   = res_ext_s[WIDTH+DIGIT-1:DIGIT];
                cnt_d   = cnt_q + CW'(1);
                if (last_s) begin
                    // On the top digit the slice inputs' MSBs are the operand sign bits.
                    s_d     = res_ext_s[WIDTH+DIGIT-1:DIGIT];
                    cout_d  = co_s;
                    ovf_d   = (a_q[DIGIT-1] == b_q[DIGIT-1]) && (sum_s[DIGIT-1] != a_q[DIGIT-1]);
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    assign bus.s     = s_q;
    assign bus.cout  = cout_q;
    assign bus.ovf   = ovf_q;
    assign bus.done  = done_q;
    assign bus.busy  = busy_q;
    assign bus.ready = ready_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed and random checks of serial_addsub at DIGIT=1, 4 and 8 (WIDTH=8).
module tb_serial_addsub;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    serial_addsub_if #(.WIDTH(8)) bus1 ();
    serial_addsub_if #(.WIDTH(8)) bus4 ();
    serial_addsub_if #(.WIDTH(8)) bus8 ();

    assign bus4.start = bus1.start;
    assign bus4.a_ns  = bus1.a_ns;
    assign bus4.cin   = bus1.cin;
    assign bus4.a     = bus1.a;
    assign bus4.b     = bus1.b;
    assign bus8.start = bus1.start;
    assign bus8.a_ns  = bus1.a_ns;
    assign bus8.cin   = bus1.cin;
    assign bus8.a     = bus1.a;
    assign bus8.b     = bus1.b;

    serial_addsub #(.WIDTH(8), .DIGIT(1)) u_d1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    serial_addsub #(.WIDTH(8), .DIGIT(4)) u_d4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    serial_addsub #(.WIDTH(8), .DIGIT(8)) u_d8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int done1_at, done4_at, done8_at, ndone1, nbusy1;
    logic ready9;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation and observe 12 cycles after the start edge; glitch>0 disturbs inputs then.
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic ans,
                          input logic ci, input int glitch);
        @(negedge clk);
        bus1.a = av; bus1.b = bv; bus1.a_ns = ans; bus1.cin = ci; bus1.start = 1'b1;
        @(posedge clk); #1;
        bus1.start = 1'b0;
        done1_at = -1; done4_at = -1; done8_at = -1; ndone1 = 0; nbusy1 = 0; ready9 = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (bus1.done) begin ndone1++; if (done1_at < 0) done1_at = k; end
            if (bus4.done && done4_at < 0) done4_at = k;
            if (bus8.done && done8_at < 0) done8_at = k;
            if (bus1.busy) nbusy1++;
            if (k == 9) ready9 = bus1.ready;
            if (glitch > 0 && k == glitch) begin
                bus1.a = 8'hFF; bus1.b = 8'hFF; bus1.a_ns = 1'b0; bus1.cin = 1'b1; bus1.start = 1'b1;
            end else if (glitch > 0 && k == glitch + 1) begin
                bus1.start = 1'b0;
            end
            @(posedge clk); #1;
        end
    endtask

    // Reference arithmetic: returns {ovf, cout, s}.
    function automatic logic [9:0] ref_op(input logic [7:0] av, input logic [7:0] bv,
                                         input logic ans, input logic ci);
        int ua, ub, sa, sb, r, sr;
        logic c, o;
        logic [7:0] sv;
        ua = int'(av); ub = int'(bv);
        sa = int'($signed(av)); sb = int'($signed(bv));
        if (ans) begin
            r = ua + ub + int'(ci); sr = sa + sb + int'(ci); c = (r > 255);
        end else begin
            r = ua - ub - int'(ci); sr = sa - sb - int'(ci); c = (r >= 0);
        end
        sv = r[7:0];
        o  = (sr > 127) || (sr < -128);
        return {o, c, sv};
    endfunction

    logic [9:0] exp_v;
    logic [7:0] ra, rb;
    logic       rans, rci;

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0;
        bus1.start = 1'b0; bus1.a_ns = 1'b1; bus1.cin = 1'b0; bus1.a = 8'h00; bus1.b = 8'h00;
        #23;
        check("rst_ready", 32'(bus1.ready), 32'd1);
        check("rst_busy",  32'(bus1.busy),  32'd0);
        check("rst_done",  32'(bus1.done),  32'd0);
        check("rst_s",     32'(bus1.s),     32'h00);
        check("rst_cout",  32'(bus1.cout),  32'd0);
        check("rst_ovf",   32'(bus1.ovf),   32'd0);
        @(negedge clk); rst_n = 1'b1;

        // 0x5A + 0x3C = 0x96, signed overflow
        run_op(8'h5A, 8'h3C, 1'b1, 1'b0, 0);
        check("ovf_add_lat1",  32'(done1_at), 32'd8);
        check("ovf_add_ndone", 32'(ndone1),   32'd1);
        check("ovf_add_busy",  32'(nbusy1),   32'd8);
        check("ovf_add_ready", 32'(ready9),   32'd1);
        check("ovf_add_s",     32'(bus1.s),   32'h96);
        check("ovf_add_cout",  32'(bus1.cout), 32'd0);
        check("ovf_add_ovf",   32'(bus1.ovf), 32'd1);
        check("d4_lat",  32'(done4_at),  32'd2);
        check("d4_s",    32'(bus4.s),    32'h96);
        check("d4_ovf",  32'(bus4.ovf),  32'd1);
        check("d8_lat",  32'(done8_at),  32'd1);
        check("d8_s",    32'(bus8.s),    32'h96);
        check("d8_ovf",  32'(bus8.ovf),  32'd1);

        run_op(8'hFF, 8'h01, 1'b1, 1'b0, 0);
        check("carry_s",    32'(bus1.s),    32'h00);
        check("carry_cout", 32'(bus1.cout), 32'd1);
        check("carry_ovf",  32'(bus1.ovf),  32'd0);

        run_op(8'hFF, 8'h01, 1'b1, 1'b1, 0);
        check("carry_cin_s",    32'(bus1.s),    32'h01);
        check("carry_cin_cout", 32'(bus1.cout), 32'd1);

        run_op(8'h10, 8'h20, 1'b0, 1'b0, 0);
        check("borrow_s",    32'(bus1.s),    32'hF0);
        check("borrow_cout", 32'(bus1.cout), 32'd0);
        check("borrow_ovf",  32'(bus1.ovf),  32'd0);

        run_op(8'h80, 8'h01, 1'b0, 1'b0, 0);
        check("sub_ovf_s",    32'(bus1.s),    32'h7F);
        check("sub_ovf_cout", 32'(bus1.cout), 32'd1);
        check("sub_ovf_ovf",  32'(bus1.ovf),  32'd1);

        // inputs and start disturbed at RUN cycle 3 must be ignored
        run_op(8'h01, 8'h01, 1'b1, 1'b0, 3);
        check("ignore_s",     32'(bus1.s),    32'h02);
        check("ignore_ndone", 32'(ndone1),    32'd1);
        check("ignore_busy",  32'(nbusy1),    32'd8);
        check("ignore_idle",  32'(bus1.ready), 32'd1);

        // reset during RUN: outputs clear at once and no done follows
        @(negedge clk);
        bus1.a = 8'h55; bus1.b = 8'h22; bus1.a_ns = 1'b1; bus1.cin = 1'b0; bus1.start = 1'b1;
        @(posedge clk); #1;
        bus1.start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check("abort_ready", 32'(bus1.ready), 32'd1);
        check("abort_busy",  32'(bus1.busy),  32'd0);
        check("abort_s",     32'(bus1.s),     32'h00);
        check("abort_cout",  32'(bus1.cout),  32'd0);
        check("abort_ovf",   32'(bus1.ovf),   32'd0);
        @(negedge clk); rst_n = 1'b1;
        ndone1 = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (bus1.done) ndone1++;
        end
        check("abort_nodone", 32'(ndone1), 32'd0);

        run_op(8'h33, 8'h11, 1'b1, 1'b0, 0);
        check("post_abort_s",   32'(bus1.s),  32'h44);
        check("post_abort_lat", 32'(done1_at), 32'd8);

        // random sweep, all three digit widths against reference arithmetic
        for (int v = 0; v < 1000; v++) begin
            ra = 8'($urandom_range(255, 0));
            rb = 8'($urandom_range(255, 0));
            rans = 1'($urandom_range(1, 0));
            rci  = 1'($urandom_range(1, 0));
            exp_v = ref_op(ra, rb, rans, rci);
            run_op(ra, rb, rans, rci, 0);
            check("rnd_d1_s",    32'(bus1.s),    32'(exp_v[7:0]));
            check("rnd_d1_cout", 32'(bus1.cout), 32'(exp_v[8]));
            check("rnd_d1_ovf",  32'(bus1.ovf),  32'(exp_v[9]));
            check("rnd_d4_s",    32'(bus4.s),    32'(exp_v[7:0]));
            check("rnd_d4_cout", 32'(bus4.cout), 32'(exp_v[8]));
            check("rnd_d4_ovf",  32'(bus4.ovf),  32'(exp_v[9]));
            check("rnd_d8_s",    32'(bus8.s),    32'(exp_v[7:0]));
            check("rnd_d8_cout", 32'(bus8.cout), 32'(exp_v[8]));
            check("rnd_d8_ovf",  32'(bus8.ovf),  32'(exp_v[9]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
Parametrised multi-cycle adder/subtractor. It processes WIDTH-bit operands DIGIT bits per clock through a registered carry, so one narrow ripple slice is reused across several cycles. It extends the single-bit add/subtract cell to arbitrary width, with a start/done handshake, carry-chain input, and signed overflow detection. It serves as the datapath arithmetic unit wherever area matters more than latency.

Parameters:
WIDTH, 8, operand/result width in bits; must be ≥2.
DIGIT, 1, bits processed per cycle; must divide WIDTH exactly (elaboration-time assertion).
N (localparam), WIDTH/DIGIT, number of RUN cycles.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only in IDLE
a_ns  in  1  1 = add (a+b+cin), 0 = subtract (a−b−cin)
cin  in  1  carry-in (add) / borrow-in (subtract)
a  in  WIDTH  operand A
b  in  WIDTH  operand B
ready  out  1  high in IDLE only
busy  out  1  high in RUN
done  out  1  one-cycle pulse, high in DONE
s  out  WIDTH  result, registered
cout  out  1  carry-out; for subtract 1 = no borrow
ovf  out  1  two's-complement signed overflow

Behaviour:
- Reset (async assert, sync release): state=IDLE; s=0, cout=0, ovf=0, done=0, busy=0, ready=1; digit counter, carry and operand registers cleared. Reset during RUN aborts the operation with no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE: on a clk edge with start=1, latch a, b, a_ns. Load b_eff = a_ns ? b : ~b and carry = a_ns ? cin : ~cin. Go to RUN with counter=0. Operands are not sampled again until the next accepted start.
- RUN: each edge, sum digit k (bits k·DIGIT+DIGIT−1 : k·DIGIT) of a and b_eff with carry. Store the sum digit in the internal result register, update carry, and increment the counter.
  - On the edge processing digit N−1: load s from the full result and cout from the final carry. Set ovf = (a[MSB] == b_eff[MSB]) && (s[MSB] != a[MSB]). Go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- Latency: done is visible N cycles after the edge that sampled start. Throughput is one operation per N+2 cycles.
- start in RUN or DONE is ignored and not queued. a_ns, cin, a and b changing during RUN have no effect.
- s, cout and ovf change only on entry to DONE (or at reset). They hold until the next completion, so they stay valid in IDLE after done.
- DIGIT=WIDTH is legal: N=1, a single RUN cycle.
- Result width is exactly WIDTH; the carry beyond the MSB is reported only on cout.

Decomposition:
- Shared package serial_addsub_pkg holds:
  - the state enum type (IDLE, RUN, DONE);
  - a clog2-based counter-width function/constant;
  - the encoding constants ADD=1'b1 and SUB=1'b0 for a_ns.
- One sub-module, addsub_digit: combinational DIGIT-bit ripple slice. Inputs x[DIGIT], y[DIGIT], ci; outputs sum[DIGIT], co. It is instantiated once, and serial_addsub feeds it the pre-inverted b_eff digit.

Test Plan (WIDTH=8, DIGIT=1 unless stated):
- Add with overflow: a=0x5A, b=0x3C, a_ns=1, cin=0, start 1 cycle → done exactly 8 cycles after the start edge; s=0x96, cout=0, ovf=1; ready returns the next cycle.
- Add with carry: a=0xFF, b=0x01, a_ns=1, cin=0 → s=0x00, cout=1, ovf=0. Repeat with cin=1 → s=0x01, cout=1.
- Subtract with borrow: a=0x10, b=0x20, a_ns=0, cin=0 → s=0xF0, cout=0, ovf=0. Then a=0x80, b=0x01, a_ns=0 → s=0x7F, cout=1, ovf=1.
- Ignored inputs: start pulsed and a/b/a_ns changed mid-RUN (a=0x01, b=0x01 add; change a to 0xFF at cycle 3) → single done, s=0x02, no second operation, busy high 8 cycles.
- Reset mid-op: assert rst_n=0 at RUN cycle 4 → s=0, cout=0, ovf=0, done never pulses; ready=1 immediately (async). The next start completes normally.
- DIGIT=4 and DIGIT=8 builds: a=0x5A, b=0x3C add → done after 2 and 1 cycles respectively, s=0x96, ovf=1. Random 1000-vector sweep of both modes matches reference arithmetic on s, cout and ovf.
